// File: rtl/trace_mem_responder.sv
// trace_mem_responder
//   Main-memory end of the write-through, no-write-allocate cache model.
//   Single-word stores go into a posted write buffer that drains one entry
//   per cycle into a local word array. Line-fill reads are answered as
//   critical-word-first bursts after a fixed access latency. Saturating
//   request counters let trace runs cross-check cache miss/store totals.
//
// Ports
//   clk, rst                 clock (rising edge), synchronous active-high reset
//   req_valid/req_ready      request handshake
//   req_we                   1 = store, 0 = line-fill read
//   req_addr, req_wdata      word address (low MEM_AW bits used), store data
//   rsp_valid/rsp_ready      read-beat handshake
//   rsp_data, rsp_last       beat data, final-beat marker
//   rd_count, wr_count       accepted reads / writes, saturating at 16'hFFFF
module trace_mem_responder #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 7,
  parameter int MEM_AW     = 10,
  parameter int LINE_WORDS = 4,
  parameter int RD_LATENCY = 3,
  parameter int WB_DEPTH   = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_last,
  output logic [15:0]       rd_count,
  output logic [15:0]       wr_count
);

  localparam int LW   = $clog2(LINE_WORDS);
  localparam int WP   = $clog2(WB_DEPTH);
  localparam int LATW = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;

  typedef enum logic [1:0] {IDLE, WAIT, BURST} state_t;

  state_t              state;
  logic [DATA_W-1:0]   mem    [2**MEM_AW];
  logic [MEM_AW-1:0]   wb_idx [WB_DEPTH];
  logic [DATA_W-1:0]   wb_dat [WB_DEPTH];
  logic [WP-1:0]       wb_wp;
  logic [WP-1:0]       wb_rp;
  logic [WP:0]         wb_cnt;
  logic                wb_full;
  logic                wb_empty;
  logic                push;
  logic                pop;
  logic                rd_acc;
  logic [MEM_AW-1:0]   req_idx;
  logic [MEM_AW-LW-1:0] line;
  logic [LW-1:0]       off;
  logic [LW-1:0]       off_nxt;
  logic [LW-1:0]       beat;
  logic [LATW-1:0]     lat;

  assign req_idx = req_addr[MEM_AW-1:0];

  generate
    if (ADDR_W > MEM_AW) begin : g_hi
      // Upper address bits alias onto the array.
      logic unused_hi;
      assign unused_hi = ^req_addr[ADDR_W-1:MEM_AW];
    end
  endgenerate

  // Full/empty come from the registered occupancy, so a pop in the same
  // cycle does not reopen the request port early.
  assign wb_full   = (wb_cnt == (WP+1)'(WB_DEPTH));
  assign wb_empty  = (wb_cnt == '0);
  // Reads wait for an empty buffer so they always see earlier stores.
  assign req_ready = (state == IDLE) && !wb_full && (req_we || wb_empty);
  assign push      = req_valid && req_ready && req_we;
  assign rd_acc    = req_valid && req_ready && !req_we;
  assign pop       = !wb_empty;
  assign off_nxt   = off + 1'b1;  // wraps within the line

  // Storage: buffer slots and the word array carry no reset; the array
  // contents survive rst. A drain is suppressed on the reset edge so that
  // pending entries are discarded rather than committed.
  always_ff @(posedge clk) begin
    if (push) begin
      wb_idx[wb_wp] <= req_idx;
      wb_dat[wb_wp] <= req_wdata;
    end
    if (pop && !rst) begin
      mem[wb_idx[wb_rp]] <= wb_dat[wb_rp];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      wb_wp     <= '0;
      wb_rp     <= '0;
      wb_cnt    <= '0;
      rd_count  <= '0;
      wr_count  <= '0;
      rsp_valid <= 1'b0;
      rsp_last  <= 1'b0;
      rsp_data  <= '0;
      lat       <= '0;
      line      <= '0;
      off       <= '0;
      beat      <= '0;
    end else begin
      if (push) wb_wp <= wb_wp + 1'b1;
      if (pop)  wb_rp <= wb_rp + 1'b1;
      wb_cnt <= wb_cnt + (WP+1)'(push) - (WP+1)'(pop);

      if (push && (wr_count != 16'hFFFF)) wr_count <= wr_count + 16'd1;
      if (rd_acc && (rd_count != 16'hFFFF)) rd_count <= rd_count + 16'd1;

      case (state)
        IDLE: begin
          if (rd_acc) begin
            line  <= req_idx[MEM_AW-1:LW];
            off   <= req_idx[LW-1:0];
            beat  <= '0;
            lat   <= LATW'(RD_LATENCY - 1);
            state <= WAIT;
          end
        end
        WAIT: begin
          if (lat == '0) begin
            state     <= BURST;
            rsp_valid <= 1'b1;
            rsp_data  <= mem[{line, off}];
            rsp_last  <= 1'b0;
          end else begin
            lat <= lat - 1'b1;
          end
        end
        BURST: begin
          // Outputs only change on a handshake, so they hold under backpressure.
          if (rsp_ready) begin
            if (beat == LW'(LINE_WORDS - 1)) begin
              state     <= IDLE;
              rsp_valid <= 1'b0;
              rsp_last  <= 1'b0;
            end else begin
              beat     <= beat + 1'b1;
              off      <= off_nxt;
              rsp_data <= mem[{line, off_nxt}];
              rsp_last <= (beat == LW'(LINE_WORDS - 2));
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_trace_mem_responder.sv
module tb_trace_mem_responder;

  localparam int ADDR_W     = 32;
  localparam int DATA_W     = 7;
  localparam int MEM_AW     = 10;
  localparam int LINE_WORDS = 4;
  localparam int RD_LATENCY = 3;
  localparam int WB_DEPTH   = 4;
  localparam int DEPTH      = 1 << MEM_AW;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic              req_we = 1'b0;
  logic [ADDR_W-1:0] req_addr = '0;
  logic [DATA_W-1:0] req_wdata = '0;
  logic              rsp_valid;
  logic              rsp_ready = 1'b1;
  logic [DATA_W-1:0] rsp_data;
  logic              rsp_last;
  logic [15:0]       rd_count;
  logic [15:0]       wr_count;

  trace_mem_responder #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_AW(MEM_AW),
    .LINE_WORDS(LINE_WORDS), .RD_LATENCY(RD_LATENCY), .WB_DEPTH(WB_DEPTH)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_last(rsp_last), .rd_count(rd_count), .wr_count(wr_count)
  );

  always #5 clk = ~clk;

  int errs = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: memory image, pending-store queue, read phase.
  logic [DATA_W-1:0] mem_m [DEPTH];
  logic [MEM_AW-1:0] q_idx [$];
  logic [DATA_W-1:0] q_dat [$];
  logic [DATA_W-1:0] beats [$];
  int   hs = 0;
  int   ph = 0;        // 0 idle, 1 waiting for data, 2 bursting
  int   since = 0;
  int   beat = 0;
  int   base_m = 0;
  int   off_m = 0;
  int   rc = 0;
  int   wc = 0;
  bit   armed = 0;
  bit   rst_prev = 0;
  bit   acc_flag = 0;
  bit   exp_rdy;
  int   widx;

  function automatic int beat_idx(input int b);
    return base_m + ((off_m + b) % LINE_WORDS);
  endfunction

  // Check outputs against the model state for the edge just passed, then
  // advance the model for the coming edge using the (stable) inputs.
  always @(negedge clk) begin
    exp_rdy = (ph == 0) && (q_idx.size() < WB_DEPTH) && (req_we || (q_idx.size() == 0));
    if (armed) begin
      chk("req_ready", req_ready, exp_rdy);
      chk("rsp_valid", rsp_valid, ph == 2);
      chk("rsp_last", rsp_last, (ph == 2) && (beat == LINE_WORDS - 1));
      if (ph == 2) chk("rsp_data", rsp_data, mem_m[beat_idx(beat)]);
      if (rst_prev) chk("rst_rsp_data", rsp_data, 0);
      chk("rd_count", rd_count, rc);
      chk("wr_count", wr_count, wc);
      if ((ph == 2) && rsp_ready) begin
        beats.push_back(rsp_data);
        hs++;
      end
    end
    rst_prev = rst;
    acc_flag = 0;
    if (rst) begin
      q_idx.delete();
      q_dat.delete();
      ph = 0; rc = 0; wc = 0; beat = 0; since = 0;
      armed = 1;
    end else begin
      acc_flag = req_valid && exp_rdy;
      if (q_idx.size() > 0) begin
        widx = q_idx.pop_front();
        mem_m[widx] = q_dat.pop_front();
      end
      if (acc_flag && req_we) begin
        q_idx.push_back(req_addr % DEPTH);
        q_dat.push_back(req_wdata);
        if (wc < 65535) wc++;
      end else if (acc_flag) begin
        if (rc < 65535) rc++;
        base_m = (req_addr % DEPTH) & ~(LINE_WORDS - 1);
        off_m  = (req_addr % DEPTH) % LINE_WORDS;
        since = 0; beat = 0; ph = 1;
      end else if (ph == 1) begin
        since++;
        if (since == RD_LATENCY) ph = 2;
      end else if ((ph == 2) && rsp_ready) begin
        if (beat == LINE_WORDS - 1) ph = 0;
        else beat++;
      end
    end
  end

  task automatic reset_dut();
    req_valid = 0;
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
  endtask

  task automatic idle(input int n);
    req_valid = 0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Leaves req_valid high so consecutive calls issue back-to-back stores.
  task automatic wr(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    int n = 0;
    req_valid = 1; req_we = 1; req_addr = a; req_wdata = d;
    do begin @(posedge clk); #1; n++; end while (!acc_flag && n < 20);
    if (!acc_flag) chk("wr_accept_timeout", 0, 1);
  endtask

  task automatic rd(input logic [ADDR_W-1:0] a, input int stall_beat,
                    input int abort_beat, input bit rnd);
    int n, k, stall_left;
    logic [DATA_W-1:0] hd;
    logic hl;
    bit aborted;
    beats.delete(); hs = 0; stall_left = 3; aborted = 0; hd = '0; hl = 0; n = 0;
    rsp_ready = 1;
    req_valid = 1; req_we = 0; req_addr = a;
    do begin @(posedge clk); #1; n++; end while (!acc_flag && n < 50);
    req_valid = 0;
    if (!acc_flag) begin chk("rd_accept_timeout", 0, 1); return; end
    k = 0;
    while (!rsp_valid && k < RD_LATENCY + 5) begin @(posedge clk); #1; k++; end
    chk("rd_latency", k, RD_LATENCY);
    n = 0;
    while (ph != 0 && n < 200) begin
      if (abort_beat >= 0 && ph == 2 && beat == abort_beat) begin
        rst = 1;
        @(posedge clk); #1;
        rst = 0;
        aborted = 1;
        chk("abort_rsp_valid", rsp_valid, 0);
        chk("abort_rd_count", rd_count, 0);
        break;
      end
      if (ph == 2 && beat == stall_beat && stall_left > 0) begin
        if (stall_left == 3) begin
          hd = rsp_data; hl = rsp_last;
        end else begin
          chk("bp_data_hold", rsp_data, hd);
          chk("bp_last_hold", rsp_last, hl);
        end
        rsp_ready = 0;
        stall_left--;
      end else begin
        rsp_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      end
      @(posedge clk); #1; n++;
    end
    if (ph != 0) chk("burst_timeout", 0, 1);
    rsp_ready = 1;
    if (!aborted) chk("handshakes", hs, LINE_WORDS);
  endtask

  logic [DATA_W-1:0] vals [5];

  initial begin
    repeat (2) @(posedge clk);
    #1;
    rst = 0;

    // Give every word a known value, then reset: the image must survive.
    for (int i = 0; i < DEPTH; i++) wr(i, DATA_W'($urandom));
    idle(3);
    reset_dut();
    idle(1);

    // Store then read back the same line, critical word first.
    wr(32'h105, 7'h2A);
    rd(32'h105, -1, -1, 0);
    chk("t1_beat0", beats[0], 7'h2A);
    for (int i = 1; i < LINE_WORDS; i++)
      chk("t1_beat", beats[i], mem_m[32'h104 + ((1 + i) % LINE_WORDS)]);
    chk("t1_rd_count", rd_count, 1);
    chk("t1_wr_count", wr_count, 1);

    // Five stores with req_valid held, then read each one back.
    reset_dut();
    for (int i = 0; i < 5; i++) begin
      vals[i] = DATA_W'($urandom);
      wr(32'h200 + i * 5, vals[i]);
    end
    idle(2);
    chk("t2_wr_count", wr_count, 5);
    for (int i = 0; i < 5; i++) begin
      rd(32'h200 + i * 5, -1, -1, 0);
      chk("t2_readback", beats[0], vals[i]);
    end

    // Backpressure on beat 1.
    rd(32'h322, 1, -1, 0);
    idle(1);

    // Upper address bits alias onto the array.
    wr(32'h0000_0405, 7'h11);
    rd(32'h0000_0005, -1, -1, 0);
    chk("alias_beat0", beats[0], 7'h11);

    // Reset during beat 2, then a fresh read of the same line.
    wr(32'h0AB, 7'h5C);
    rd(32'h0AB, -1, 2, 0);
    idle(1);
    rd(32'h0AB, -1, -1, 0);
    chk("post_abort_beat0", beats[0], 7'h5C);

    // Mixed random traffic with random response backpressure.
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 1)) wr($urandom_range(0, 63) | ($urandom << MEM_AW), DATA_W'($urandom));
      else rd($urandom_range(0, 63) | ($urandom << MEM_AW), -1, -1, 1);
    end
    idle(3);

    // Store counter saturation.
    reset_dut();
    for (int i = 0; i < 65537; i++) wr($urandom, DATA_W'($urandom));
    idle(3);
    chk("wr_count_sat", wr_count, 16'hFFFF);
    wr($urandom, DATA_W'($urandom));
    idle(3);
    chk("wr_count_hold", wr_count, 16'hFFFF);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
